// File: rtl/hazard_scheduler.sv
// Decode-stage issue controller: RAW scoreboard over EXE/MEM, branch flush,
// memory-busy freeze, and drained switching of the forwarding mode.
module hazard_scheduler #(
    parameter logic FWD_RESET = 1'b0,
    parameter int   CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [3:0]       id_dest,
    input  logic             br_taken,
    input  logic             mem_ready,
    input  logic             fwd_req,
    input  logic             stat_clr,
    output logic             hazard,
    output logic             flush,
    output logic             freeze,
    output logic             fwd_active,
    output logic             draining,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       load;
    } slot_t;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e           state_q, state_d;
    logic             fwd_active_q, fwd_active_d;
    slot_t            exe_q, exe_d;
    slot_t            mem_q, mem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             raw;

    function automatic logic slot_match(input slot_t s, input logic [3:0] src1,
                                        input logic [3:0] src2, input logic two_src);
        return s.valid & ((s.dest == src1) | (two_src & (s.dest == src2)));
    endfunction

    assign freeze = ~mem_ready;
    assign flush  = br_taken & mem_ready;

    // With forwarding only a load still in EXE cannot be bypassed in time.
    always_comb begin
        raw = 1'b0;
        if (id_valid) begin
            if (fwd_active_q)
                raw = exe_q.load & slot_match(exe_q, id_src1, id_src2, id_two_src);
            else
                raw = slot_match(exe_q, id_src1, id_src2, id_two_src)
                    | slot_match(mem_q, id_src1, id_src2, id_two_src);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            fwd_active_q <= FWD_RESET;
        end else begin
            state_q      <= state_d;
            fwd_active_q <= fwd_active_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        fwd_active_d = fwd_active_q;
        if (!freeze) begin
            unique case (state_q)
                RUN: begin
                    if (fwd_req != fwd_active_q)
                        state_d = DRAIN;
                end
                DRAIN: begin
                    if (!exe_q.valid && !mem_q.valid) begin
                        state_d      = RUN;
                        fwd_active_d = fwd_req;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        draining = (state_q == DRAIN);
        hazard   = (raw | draining) & ~flush & ~freeze;
    end

    always_comb begin
        mem_d = exe_q;
        exe_d = '0;
        if (id_valid && !hazard && !flush)
            exe_d = '{valid: id_wb_en, dest: id_dest, load: id_mem_r_en};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q <= '0;
            mem_q <= '0;
        end else if (!freeze) begin
            exe_q <= exe_d;
            mem_q <= mem_d;
        end
    end

    // Clear acts even while frozen; counting only happens on live edges.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr)
            stall_cnt_d = '0;
        else if (!freeze && hazard && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign fwd_active = fwd_active_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler; expectations are hand-derived cycle by cycle.
module tb_hazard_scheduler;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_two_src, id_wb_en, id_mem_r_en;
    logic [3:0]       id_src1, id_src2, id_dest;
    logic             br_taken, mem_ready, fwd_req, stat_clr;
    logic             hazard, flush, freeze, fwd_active, draining;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scheduler #(.FWD_RESET(1'b0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_dest(id_dest), .br_taken(br_taken), .mem_ready(mem_ready),
        .fwd_req(fwd_req), .stat_clr(stat_clr),
        .hazard(hazard), .flush(flush), .freeze(freeze),
        .fwd_active(fwd_active), .draining(draining), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        id_wb_en = 0; id_mem_r_en = 0; id_dest = 0; br_taken = 0; stat_clr = 0;
    endtask

    task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                         input logic wb, input logic ld, input logic [3:0] dst);
        id_valid = 1; id_src1 = s1; id_src2 = s2; id_two_src = two;
        id_wb_en = wb; id_mem_r_en = ld; id_dest = dst;
    endtask

    task automatic test_reset();
        rst = 0; mem_ready = 0; fwd_req = 0; idle();
        #3;
        n_cmp++; if (freeze !== 1'b1) begin n_err++; $display("FAIL rst_freeze got %b want 1", freeze); end
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL rst_frozen_hazard got %b want 0", hazard); end
        mem_ready = 1;
        repeat (2) @(negedge clk);
        rst = 1;
        tick();
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL rst_hazard got %b want 0", hazard); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got %b want 0", flush); end
        n_cmp++; if (freeze !== 1'b0) begin n_err++; $display("FAIL rst_freeze_run got %b want 0", freeze); end
        n_cmp++; if (draining !== 1'b0) begin n_err++; $display("FAIL rst_draining got %b want 0", draining); end
        n_cmp++; if (fwd_active !== 1'b0) begin n_err++; $display("FAIL rst_fwd got %b want 0", fwd_active); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", stall_cnt); end
    endtask

    // No forwarding: consumer waits out EXE and MEM, two bubbles.
    task automatic test_raw_nofwd();
        issue(0, 0, 0, 1, 0, 3); #1;
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL raw_first hazard got %b want 0", hazard); end
        tick();
        issue(3, 4, 1, 1, 0, 6); #1;
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL raw_exe hazard got %b want 1", hazard); end
        tick();
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL raw_mem hazard got %b want 1", hazard); end
        n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL raw_cnt1 got %0d want 1", stall_cnt); end
        tick();
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL raw_issue hazard got %b want 0", hazard); end
        n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL raw_cnt2 got %0d want 2", stall_cnt); end
        tick();
        idle();
        repeat (2) tick();
    endtask

    task automatic test_freeze();
        issue(0, 0, 0, 1, 0, 3); tick();
        issue(3, 0, 0, 0, 0, 0); #1;
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL frz_pre hazard got %b want 1", hazard); end
        tick();
        mem_ready = 0; #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (freeze !== 1'b1 || hazard !== 1'b0) begin n_err++; $display("FAIL frz_hold%0d freeze/hazard got %b%b want 10", i, freeze, hazard); end
            n_cmp++; if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL frz_cnt%0d got %0d want 3", i, stall_cnt); end
            tick();
        end
        mem_ready = 1; #1;
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL frz_resume hazard got %b want 1", hazard); end
        tick();
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL frz_done hazard got %b want 0", hazard); end
        n_cmp++; if (stall_cnt !== 4'd4) begin n_err++; $display("FAIL frz_cnt_end got %0d want 4", stall_cnt); end
        idle();
        mem_ready = 0; stat_clr = 1; tick();
        stat_clr = 0; #1;
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL frz_clr got %0d want 0", stall_cnt); end
        mem_ready = 1;
        repeat (2) tick();
    endtask

    task automatic test_flush();
        issue(0, 0, 0, 1, 0, 3); tick();
        issue(3, 0, 0, 1, 0, 7); br_taken = 1; #1;
        n_cmp++; if (flush !== 1'b1 || hazard !== 1'b0) begin n_err++; $display("FAIL fl_win flush/hazard got %b%b want 10", flush, hazard); end
        tick();
        br_taken = 0; issue(7, 0, 0, 0, 0, 0); #1;
        n_cmp++; if (hazard !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL fl_bubble hazard/flush got %b%b want 00", hazard, flush); end
        issue(3, 0, 0, 0, 0, 0); #1;
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL fl_mem_r3 hazard got %b want 1", hazard); end
        mem_ready = 0; br_taken = 1; #1;
        n_cmp++; if (flush !== 1'b0 || hazard !== 1'b0) begin n_err++; $display("FAIL fl_frozen flush/hazard got %b%b want 00", flush, hazard); end
        mem_ready = 1; idle();
        repeat (2) tick();
    endtask

    // Two valid slots when the switch is requested: two drain cycles.
    task automatic test_fwd_switch();
        issue(0, 0, 0, 1, 0, 1); tick();
        issue(0, 0, 0, 1, 0, 2); tick();
        idle(); fwd_req = 1; #1;
        n_cmp++; if (draining !== 1'b0 || hazard !== 1'b0) begin n_err++; $display("FAIL sw_req draining/hazard got %b%b want 00", draining, hazard); end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (draining !== 1'b1 || hazard !== 1'b1) begin n_err++; $display("FAIL sw_drain%0d draining/hazard got %b%b want 11", i, draining, hazard); end
            n_cmp++; if (fwd_active !== 1'b0) begin n_err++; $display("FAIL sw_fwd_old%0d got %b want 0", i, fwd_active); end
            tick();
        end
        n_cmp++; if (draining !== 1'b0 || hazard !== 1'b0) begin n_err++; $display("FAIL sw_done draining/hazard got %b%b want 00", draining, hazard); end
        n_cmp++; if (fwd_active !== 1'b1) begin n_err++; $display("FAIL sw_fwd_new got %b want 1", fwd_active); end
        n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL sw_cnt got %0d want 2", stall_cnt); end
    endtask

    task automatic test_load_use();
        issue(0, 0, 0, 1, 1, 5); tick();
        issue(1, 5, 1, 1, 0, 8); #1;
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL lu_stall hazard got %b want 1", hazard); end
        tick();
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL lu_one hazard got %b want 0", hazard); end
        tick();
        issue(0, 0, 0, 1, 1, 5); tick();
        issue(2, 5, 0, 0, 0, 0); #1;
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL lu_nosrc2 hazard got %b want 0", hazard); end
        issue(0, 0, 0, 1, 0, 9); tick();
        issue(9, 0, 0, 0, 0, 0); #1;
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL lu_alu_fwd hazard got %b want 0", hazard); end
        idle();
        repeat (2) tick();
    endtask

    // Request withdrawn mid-drain: the drain still completes.
    task automatic test_withdraw();
        issue(0, 0, 0, 1, 0, 1); tick();
        idle(); fwd_req = 0; tick();
        fwd_req = 1; #1;
        n_cmp++; if (draining !== 1'b1) begin n_err++; $display("FAIL wd_drain0 got %b want 1", draining); end
        tick();
        n_cmp++; if (draining !== 1'b1) begin n_err++; $display("FAIL wd_drain1 got %b want 1", draining); end
        tick();
        n_cmp++; if (draining !== 1'b0 || fwd_active !== 1'b1) begin n_err++; $display("FAIL wd_done draining/fwd got %b%b want 01", draining, fwd_active); end
    endtask

    task automatic test_reset_mid_drain();
        fwd_req = 0; tick();
        n_cmp++; if (draining !== 1'b1) begin n_err++; $display("FAIL rmd_pre got %b want 1", draining); end
        rst = 0; #1;
        n_cmp++; if (draining !== 1'b0 || fwd_active !== 1'b0 || hazard !== 1'b0) begin n_err++; $display("FAIL rmd_async draining/fwd/hazard got %b%b%b want 000", draining, fwd_active, hazard); end
        @(negedge clk); rst = 1;
        tick();
    endtask

    task automatic test_saturate();
        issue(3, 0, 0, 1, 0, 3);
        repeat (30) tick();
        n_cmp++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_hold got %0d want 15", stall_cnt); end
        tick();
        n_cmp++; if (hazard !== 1'b1) begin n_err++; $display("FAIL sat_hazard got %b want 1", hazard); end
        stat_clr = 1; tick();
        stat_clr = 0; idle(); #1;
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL sat_clr got %0d want 0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_raw_nofwd();
        test_freeze();
        test_flush();
        test_fwd_switch();
        test_load_use();
        test_withdraw();
        test_reset_mid_drain();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Issue controller for the decode stage: holds a 2-slot scoreboard of in-flight register writes (EXE, MEM), raises the decode-stage hazard (stall) on RAW conflicts, generates the branch flush, and freezes the whole pipeline while data memory is busy.
- Sequences forwarding-mode changes safely: a requested mode switch drains the pipeline before it takes effect.
- Sits beside the decode stage. It feeds hazard to decode and the PC/IF-ID registers, flush to the IF and ID stage registers, and freeze to all pipeline registers.

Parameters:
- FWD_RESET, 1'b0, forwarding mode loaded into fwd_active at reset.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock; everything updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- id_valid  in  1  decode holds a real instruction (not a bubble).
- id_src1  in  4  Rn index.
- id_src2  in  4  Rm index, or Rd for stores.
- id_two_src  in  1  id_src2 is read.
- id_wb_en  in  1  instruction writes a register.
- id_mem_r_en  in  1  instruction is a load.
- id_dest  in  4  destination register.
- br_taken  in  1  branch resolved taken in EXE.
- mem_ready  in  1  data memory can complete; 0 = freeze.
- fwd_req  in  1  requested forwarding mode.
- stat_clr  in  1  synchronous clear of stall_cnt.
- hazard  out  1  stall decode, hold PC and IF/ID, insert bubble.
- flush  out  1  squash IF/ID and ID/EXE contents.
- freeze  out  1  hold every pipeline register.
- fwd_active  out  1  forwarding mode currently in force.
- draining  out  1  FSM in DRAIN.
- stall_cnt  out  CNT_W  saturating count of hazard cycles.

Behaviour:
- Reset (rst=0, asynchronous): both slots invalid; state RUN; fwd_active=FWD_RESET; stall_cnt=0. After reset the outputs are hazard=0, flush=0, draining=0, freeze=~mem_ready.
- Slot contents: {valid, dest[3:0], load}. Slot EXE shifts into slot MEM every unfrozen edge; the MEM slot content then retires.
- The WB stage is not tracked. The register file write completes before the same-cycle read.
- freeze = ~mem_ready, combinational. When freeze=1: no slot, state or counter update. hazard and flush are forced to 0 (freeze dominates).
- flush = br_taken & mem_ready. During flush, hazard is forced to 0.
- Match rule, per slot s: s.valid & (s.dest==id_src1 | (id_two_src & s.dest==id_src2)). Evaluated only when id_valid=1.
- raw, fwd_active=0: match on slot EXE or slot MEM.
- raw, fwd_active=1: match on slot EXE with EXE.load=1 only (load-use). This yields exactly one bubble cycle.
- hazard = (raw | state==DRAIN) & ~flush & ~freeze.
- EXE slot load on an unfrozen edge: it takes {id_wb_en, id_dest, id_mem_r_en} when id_valid & ~hazard & ~flush. Otherwise it takes invalid (bubble).
- FSM, RUN -> DRAIN: when fwd_req != fwd_active on an unfrozen edge.
- FSM, DRAIN -> RUN: when both slots are invalid at the edge. fwd_active <= fwd_req on that same edge.
- FSM, request withdrawn: if fwd_req returns to fwd_active while in DRAIN, the FSM still completes the drain (no abort).
- stall_cnt: +1 on each unfrozen edge with hazard=1. It saturates at all-ones.
- stall_cnt clear: stat_clr=1 clears it to 0, taking priority over increment. stat_clr also acts while frozen.
- Reset mid-drain or mid-freeze: the async reset returns everything to the reset values immediately.
- Simultaneous br_taken and raw: flush wins, no hazard. The squashed ID instruction enters no slot.

Test Plan:
- Reset with rst=0 then release, mem_ready=1, idle inputs -> hazard=0, flush=0, freeze=0, fwd_active=FWD_RESET, stall_cnt=0.
- fwd_active=0; issue ADD R3; next cycle SUB with Rn=R3 -> hazard=1 for exactly 2 cycles, then issues; stall_cnt=2.
- fwd_active=1; issue LDR R5; next cycle ADD with Rm=R5, id_two_src=1 -> hazard=1 for 1 cycle. With id_two_src=0 and Rn≠R5 -> no hazard.
- mem_ready=0 for 3 cycles while slots are valid and a raw condition exists -> freeze=1, hazard=0, slots and stall_cnt unchanged. On resume the prior stall sequence continues.
- br_taken=1 together with a raw condition -> flush=1, hazard=0. The next cycle sees slot EXE as a bubble.
- fwd_req 0->1 with two valid slots -> draining=1 and hazard=1 for 2 cycles; fwd_active becomes 1 on the edge where the slots are empty. Separately: force stall_cnt to all-ones -> it stays saturated; stat_clr -> 0.
